// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing sequence generator.
// Holds the sequence-mode encoding, the controller state encoding, the
// default scramble mask word and a width-generic bit-reverse helper.
package sc_pkg;

  typedef enum logic [1:0] {
    SEQ_CNT     = 2'd0,
    SEQ_VDC     = 2'd1,
    SEQ_VDC_SCR = 2'd2,
    SEQ_RSVD    = 2'd3
  } sc_seq_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sc_state_e;

  // Widest sequence word the helpers below can handle.
  localparam int unsigned SC_MAX_W = 32;

  // Per-channel scramble mask used when no mask is supplied.
  localparam logic [SC_MAX_W-1:0] SC_DEFAULT_MASK_WORD = 32'h0000_0000;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [SC_MAX_W-1:0] sc_bitrev(input logic [SC_MAX_W-1:0] x,
                                                    input int unsigned w);
    logic [SC_MAX_W-1:0] full_rev_s;
    full_rev_s = {<<{x}};
    return full_rev_s >> (SC_MAX_W - w);
  endfunction

endpackage

// File: rtl/sc_seq_chan.sv
// One channel of the sequence generator: maps the shared counter to this
// channel's sequence word and compares it against the channel's probability.
module sc_seq_chan
  import sc_pkg::*;
#(
  parameter int unsigned N = 12
) (
  input  logic [N-1:0]  count,
  input  sc_seq_mode_e  mode_q,
  input  logic [N-1:0]  mask,
  input  logic [N-1:0]  value_q,
  output logic [N-1:0]  seq,
  output logic          cmp
);

  logic [SC_MAX_W-1:0] count_wide_s;
  logic [SC_MAX_W-1:0] rev_wide_s;
  logic [N-1:0]        rev_s;
  logic [N-1:0]        seq_s;

  assign count_wide_s = SC_MAX_W'(count);
  assign rev_wide_s   = sc_bitrev(count_wide_s, N);
  assign rev_s        = rev_wide_s[N-1:0];

  // Select the sequence word; the reserved mode falls back to plain van der Corput.
  always_comb begin
    seq_s = rev_s;
    case (mode_q)
      SEQ_CNT:     seq_s = count;
      SEQ_VDC:     seq_s = rev_s;
      SEQ_VDC_SCR: seq_s = rev_s ^ mask;
      SEQ_RSVD:    seq_s = rev_s;
      default:     seq_s = rev_s;
    endcase
  end

  assign seq = seq_s;
  // Strict N-bit unsigned compare: value 0 never fires, all-ones misses only seq = all-ones.
  assign cmp = (value_q > seq_s);

endmodule

// File: rtl/sc_ldseq_gen.sv
// Multi-channel low-discrepancy sequence generator / stochastic number
// generator. One start runs a 2^N-tick period; each advancing tick emits one
// registered comparator bit per channel for the current counter value.
module sc_ldseq_gen
  import sc_pkg::*;
#(
  parameter int unsigned       N        = 12,
  parameter int unsigned       CH       = 4,
  parameter logic [CH*N-1:0]   SCR_MASK = {CH{SC_DEFAULT_MASK_WORD[N-1:0]}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CH*N-1:0]   value,
  input  logic              enable,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      count_out,
  output logic [CH*N-1:0]   seq_out,
  output logic [CH-1:0]     stream,
  output logic              stream_valid
);

  localparam logic [N-1:0] COUNT_LAST = {N{1'b1}};

  sc_state_e         state_r;
  logic [N-1:0]      count_r;
  sc_seq_mode_e      mode_q_r;
  logic [CH*N-1:0]   value_q_r;
  logic              busy_r;
  logic              done_r;
  logic [CH-1:0]     stream_r;
  logic              stream_valid_r;
  logic [CH-1:0]     cmp_s;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    sc_seq_chan #(
      .N (N)
    ) u_chan (
      .count   (count_r),
      .mode_q  (mode_q_r),
      .mask    (SCR_MASK[gi*N +: N]),
      .value_q (value_q_r[gi*N +: N]),
      .seq     (seq_out[gi*N +: N]),
      .cmp     (cmp_s[gi])
    );
  end

  // Period controller: start restarts from any state, advancing ticks register the stream bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      count_r        <= {N{1'b0}};
      mode_q_r       <= SEQ_CNT;
      value_q_r      <= {(CH*N){1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      stream_r       <= {CH{1'b0}};
      stream_valid_r <= 1'b0;
    end else if (start) begin
      state_r        <= ST_RUN;
      count_r        <= {N{1'b0}};
      mode_q_r       <= sc_seq_mode_e'(mode);
      value_q_r      <= value;
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
      stream_valid_r <= 1'b0;
    end else if ((state_r == ST_RUN) && enable) begin
      stream_r       <= cmp_s;
      stream_valid_r <= 1'b1;
      count_r        <= count_r + N'(1'b1);
      if (count_r == COUNT_LAST) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end else begin
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end
    end else begin
      stream_valid_r <= 1'b0;
      done_r         <= 1'b0;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign count_out    = count_r;
  assign stream       = stream_r;
  assign stream_valid = stream_valid_r;

endmodule

// File: tb/tb_sc_ldseq_gen.sv
// Self-checking bench for sc_ldseq_gen: a 3-bit, 2-channel instance checked
// every cycle against a queue-based reference model, plus a default 12-bit
// instance used for full-period extremes and permutation checks.
module tb_sc_ldseq_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  // small instance (N=3, CH=2, ch1 mask 3'b101)
  logic        start, enable;
  logic [1:0]  mode;
  logic [5:0]  value;
  logic        busy, done, stream_valid;
  logic [2:0]  count_out;
  logic [5:0]  seq_out;
  logic [1:0]  stream;
  // default instance (N=12, CH=4)
  logic        bg_start, bg_enable;
  logic [1:0]  bg_mode;
  logic [47:0] bg_value;
  logic        bg_busy, bg_done, bg_sv;
  logic [11:0] bg_count;
  logic [47:0] bg_seq;
  logic [3:0]  bg_stream;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  sc_ldseq_gen #(.N(3), .CH(2), .SCR_MASK(6'b101_000)) u_small (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .value(value),
    .enable(enable), .busy(busy), .done(done), .count_out(count_out),
    .seq_out(seq_out), .stream(stream), .stream_valid(stream_valid));

  sc_ldseq_gen u_big (
    .clock(clock), .reset_n(reset_n), .start(bg_start), .mode(bg_mode), .value(bg_value),
    .enable(bg_enable), .busy(bg_busy), .done(bg_done), .count_out(bg_count),
    .seq_out(bg_seq), .stream(bg_stream), .stream_valid(bg_sv));

  // ---------------- reference model (small instance) ----------------
  typedef struct { int s0; int s1; bit b0; bit b1; } tick_t;
  tick_t exp_q[$];
  int    m_mode;
  int    m_val[2];
  bit    m_run, m_busy, m_done, m_sv;
  bit [1:0] m_stream;

  function automatic int seq_of(int md, int k, int ch);
    int r;
    r = 0;
    for (int b = 0; b < 3; b++)
      if (((k >> b) & 1) != 0) r = r | (1 << (2 - b));
    case (md)
      0:       return k;
      2:       return r ^ ((ch == 1) ? 5 : 0);
      default: return r;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_val[0] = 0; m_val[1] = 0;
    m_run = 0; m_busy = 0; m_done = 0; m_sv = 0; m_stream = 2'b00;
  endtask

  task automatic model_step(input bit st, input bit en);
    tick_t t;
    if (st) begin
      m_mode = int'(mode);
      m_val[0] = int'(value[2:0]);
      m_val[1] = int'(value[5:3]);
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
        t.s0 = seq_of(m_mode, k, 0);
        t.s1 = seq_of(m_mode, k, 1);
        t.b0 = (m_val[0] > t.s0);
        t.b1 = (m_val[1] > t.s1);
        exp_q.push_back(t);
      end
      m_run = 1; m_busy = 1; m_sv = 0; m_done = 0;
    end else if (m_run && en) begin
      t = exp_q.pop_front();
      m_stream = {t.b1, t.b0};
      m_sv = 1;
      m_done = (exp_q.size() == 0);
      if (m_done) begin m_run = 0; m_busy = 0; end
    end else begin
      m_sv = 0; m_done = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // per-cycle comparison of every small-instance output against the model
  task automatic compare_all();
    int ec, es;
    ec = m_run ? (8 - exp_q.size()) : 0;
    if (m_run) es = (exp_q[0].s1 << 3) | exp_q[0].s0;
    else       es = (seq_of(m_mode, 0, 1) << 3) | seq_of(m_mode, 0, 0);
    check("busy",         64'(busy),         64'(m_busy));
    check("done",         64'(done),         64'(m_done));
    check("stream_valid", 64'(stream_valid), 64'(m_sv));
    check("stream",       64'(stream),       64'(m_stream));
    check("count_out",    64'(count_out),    64'(ec));
    check("seq_out",      64'(seq_out),      64'(es));
    if (done === 1'b1) done_cnt++;
  endtask

  // logs of observed behaviour for literal checks
  logic [7:0]  lg0, lg1;
  logic [23:0] lgs0, lgs1;
  int          lgv;

  task automatic clear_log();
    lg0 = 8'h00; lg1 = 8'h00; lgs0 = 24'h0; lgs1 = 24'h0; lgv = 0;
  endtask

  // one clock cycle: drive inputs, step model at the edge, compare on the falling edge
  task automatic cyc(input bit st, input bit en);
    start = st; enable = en;
    if (busy && en && !st) begin
      lgs0 = {lgs0[20:0], seq_out[2:0]};
      lgs1 = {lgs1[20:0], seq_out[5:3]};
    end
    @(posedge clock);
    model_step(st, en);
    @(negedge clock);
    compare_all();
    if (stream_valid) begin
      lg0 = {lg0[6:0], stream[0]};
      lg1 = {lg1[6:0], stream[1]};
      lgv++;
    end
  endtask

  // full period on the default instance: ones per channel, seq permutation, single done
  task automatic big_period(input logic [1:0] md, input logic [47:0] v);
    int seen[4096];
    int ones[4];
    int nvalid, ndist;
    bit got_done;
    foreach (seen[i]) seen[i] = 0;
    for (int c = 0; c < 4; c++) ones[c] = 0;
    nvalid = 0; got_done = 0;
    bg_mode = md; bg_value = v; bg_start = 1'b1;
    @(negedge clock);
    bg_start = 1'b0;
    for (int t = 0; t < 5000 && !got_done; t++) begin
      if (bg_busy) seen[bg_seq[11:0]]++;
      if (bg_sv) begin
        nvalid++;
        for (int c = 0; c < 4; c++) ones[c] += int'(bg_stream[c]);
      end
      if (bg_done) got_done = 1;
      else @(negedge clock);
    end
    check("big_done_seen", 64'(got_done), 64'd1);
    check("big_busy_at_done", 64'(bg_busy), 64'd0);
    check("big_valid_bits", 64'(nvalid), 64'd4096);
    for (int c = 0; c < 4; c++)
      check("big_ones", 64'(ones[c]), 64'(v[c*12 +: 12]));
    ndist = 0;
    foreach (seen[i]) if (seen[i] == 1) ndist++;
    check("big_seq_perm", 64'(ndist), 64'd4096);
    @(negedge clock);
    check("big_done_pulse", 64'(bg_done), 64'd0);
    check("big_valid_after", 64'(bg_sv), 64'd0);
  endtask

  initial begin
    int didx, dsnap;
    logic [23:0] pin;
    logic [3:0]  pat;
    logic [47:0] bv;

    reset_n = 1'b0; start = 1'b0; enable = 1'b0; mode = 2'd0; value = 6'd0;
    bg_start = 1'b0; bg_enable = 1'b1; bg_mode = 2'd0; bg_value = 48'd0;
    model_reset();
    clear_log();
    #1;
    check("rst_busy",   64'(busy),         64'd0);
    check("rst_done",   64'(done),         64'd0);
    check("rst_sv",     64'(stream_valid), 64'd0);
    check("rst_stream", 64'(stream),       64'd0);
    check("rst_count",  64'(count_out),    64'd0);
    check("rst_seq",    64'(seq_out),      64'd0);

    // pin the model's sequence function against hand-derived orders
    pin = 24'h0;
    for (int k = 0; k < 8; k++) pin = {pin[20:0], 3'(seq_of(1, k, 0))};
    check("model_vdc_order", 64'(pin), 64'(24'o04261537));
    pin = 24'h0;
    for (int k = 0; k < 8; k++) pin = {pin[20:0], 3'(seq_of(2, k, 1))};
    check("model_scr_order", 64'(pin), 64'(24'o51734062));

    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    // 1: basic period, mode 1, ch0=5 ch1=2
    mode = 2'd1; value = {3'd2, 3'd5};
    clear_log(); didx = -1;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1);
      if (done && didx < 0) didx = i;
    end
    cyc(1'b0, 1'b1);
    check("t1_seq",       64'(lgs0), 64'(24'o04261537));
    check("t1_stream_c0", 64'(lg0),  64'(8'b11101010));
    check("t1_stream_c1", 64'(lg1),  64'(8'b10001000));
    check("t1_done_tick", 64'(didx), 64'd7);
    check("t1_done_cnt",  64'(done_cnt), 64'd1);

    // 2: scrambled mode, ch1 mask 101, ch1=4
    mode = 2'd2; value = {3'd4, 3'd3};
    clear_log();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
    check("t2_seq_c1",    64'(lgs1), 64'(24'o51734062));
    check("t2_stream_c1", 64'(lg1),  64'(8'b01010101));

    // 3: stall pattern 1,0,0,1
    mode = 2'd1; value = {3'd2, 3'd5};
    clear_log(); didx = -1; pat = 4'b1001;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, pat[3 - (i % 4)]);
      if (done && didx < 0) didx = i;
    end
    cyc(1'b0, 1'b0);
    check("t3_valid_bits", 64'(lgv),  64'd8);
    check("t3_stream_c0",  64'(lg0),  64'(8'b11101010));
    check("t3_stream_c1",  64'(lg1),  64'(8'b10001000));
    check("t3_done_tick",  64'(didx), 64'd15);

    // 4: restart at tick 5 with mode 0, ch0=7 ch1=0
    mode = 2'd1; value = {3'd2, 3'd5};
    dsnap = done_cnt;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    mode = 2'd0; value = {3'd0, 3'd7};
    clear_log();
    cyc(1'b1, 1'b1);
    check("t4_abort_nodone", 64'(done_cnt - dsnap), 64'd0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
    check("t4_seq",       64'(lgs0), 64'(24'o01234567));
    check("t4_stream_c0", 64'(lg0),  64'(8'b11111110));
    check("t4_stream_c1", 64'(lg1),  64'(8'b00000000));
    check("t4_done_cnt",  64'(done_cnt - dsnap), 64'd1);

    // 5: async reset mid-period at count 3
    mode = 2'd1; value = {3'd2, 3'd5};
    dsnap = done_cnt;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    check("t5_count_pre", 64'(count_out), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy",   64'(busy),         64'd0);
    check("t5_sv",     64'(stream_valid), 64'd0);
    check("t5_stream", 64'(stream),       64'd0);
    check("t5_count",  64'(count_out),    64'd0);
    check("t5_seq",    64'(seq_out),      64'd0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    check("t5_no_done", 64'(done_cnt - dsnap), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit st;
      st = ($urandom_range(0, 24) == 0);
      if (st) begin
        mode  = 2'($urandom_range(0, 3));
        value = 6'($urandom_range(0, 63));
      end
      cyc(st, ($urandom_range(0, 3) != 0));
    end

    // 6: extremes on the default 12-bit instance
    bv = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'd4095, 12'd0};
    big_period(2'd1, bv);
    bv = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
    big_period(2'd0, bv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
